// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: a combinational decoder writes into a
// DEPTH-entry valid/ready FIFO towards execute; tracks illegal words.

package decode_pkg;

  localparam int unsigned IMM_W = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef struct packed {
    logic branch;
    logic link;
    logic expect_zero;
    logic use_imm;
    logic pc_src1;
    logic mem_read;
    logic mem_write;
    logic is_ecall;
    logic is_ebreak;
  } instr_flags_t;

  typedef struct packed {
    instr_flags_t     flags;
    logic [3:0]       alu_op;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [IMM_W-1:0] imm;
  } instruction_t;

  function automatic instruction_t nop_instr();
    instruction_t n;
    n               = '0;
    n.flags.use_imm = 1'b1;
    n.alu_op        = ALU_ADD;
    return n;
  endfunction

endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned CNT_W          = 8,
  parameter bit          ENABLE_SUBWORD = 1'b1,
  parameter bit          ENABLE_ECALL   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_word,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output instruction_t       out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic [1:0]         out_mem_size,
  output logic               out_mem_unsigned,
  output logic               out_illegal,
  output logic               error,
  output logic [CNT_W-1:0]   illegal_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    instruction_t    instr;
    logic [XLEN-1:0] pc;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            illegal;
  } entry_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  logic [6:0]       opcode_s;
  logic [2:0]       funct3_s;
  logic [6:0]       funct7_s;
  logic [4:0]       rd_s;
  logic [4:0]       rs1_s;
  logic [4:0]       rs2_s;
  logic [IMM_W-1:0] imm_i_s;
  logic [IMM_W-1:0] imm_s_s;
  logic [IMM_W-1:0] imm_b_s;
  logic [IMM_W-1:0] imm_u_s;
  logic [IMM_W-1:0] imm_j_s;
  logic [IMM_W-1:0] imm_sh_s;

  assign opcode_s = in_word[6:0];
  assign rd_s     = in_word[11:7];
  assign funct3_s = in_word[14:12];
  assign rs1_s    = in_word[19:15];
  assign rs2_s    = in_word[24:20];
  assign funct7_s = in_word[31:25];
  assign imm_i_s  = IMM_W'($signed(in_word[31:20]));
  assign imm_s_s  = IMM_W'($signed({in_word[31:25], in_word[11:7]}));
  assign imm_b_s  = IMM_W'($signed({in_word[31], in_word[7], in_word[30:25], in_word[11:8], 1'b0}));
  assign imm_u_s  = IMM_W'($signed({in_word[31:12], 12'b0}));
  assign imm_j_s  = IMM_W'($signed({in_word[31], in_word[19:12], in_word[20], in_word[30:21], 1'b0}));
  assign imm_sh_s = IMM_W'(in_word[24:20]);

  instruction_t dec_instr_s;
  logic [1:0]   dec_size_s;
  logic         dec_unsigned_s;
  logic         dec_subword_s;
  logic         dec_bad_s;
  logic         dec_illegal_s;
  entry_t       entry_s;

  // Decoder: starts from the NOP record and fills in per opcode.
  always_comb begin
    dec_instr_s    = nop_instr();
    dec_size_s     = SZ_BYTE;
    dec_unsigned_s = 1'b0;
    dec_subword_s  = 1'b0;
    dec_bad_s      = 1'b0;
    case (opcode_s)
      OP_LUI: begin
        dec_instr_s.alu_op = ALU_XOR;
        dec_instr_s.rd     = rd_s;
        dec_instr_s.imm    = imm_u_s;
      end
      OP_AUIPC: begin
        dec_instr_s.flags.pc_src1 = 1'b1;
        dec_instr_s.rd            = rd_s;
        dec_instr_s.imm           = imm_u_s;
      end
      OP_JAL: begin
        dec_instr_s.flags.branch      = 1'b1;
        dec_instr_s.flags.link        = 1'b1;
        dec_instr_s.flags.expect_zero = 1'b1;
        dec_instr_s.flags.use_imm     = 1'b0;
        dec_instr_s.rd                = rd_s;
        dec_instr_s.imm               = imm_j_s;
      end
      OP_JALR: begin
        dec_instr_s.flags.branch      = 1'b1;
        dec_instr_s.flags.link        = 1'b1;
        dec_instr_s.flags.expect_zero = 1'b1;
        dec_instr_s.rd                = rd_s;
        dec_instr_s.rs1               = rs1_s;
        dec_instr_s.imm               = imm_i_s;
        dec_bad_s                     = (funct3_s != 3'b000);
      end
      OP_BRANCH: begin
        dec_instr_s.flags.branch  = 1'b1;
        dec_instr_s.flags.use_imm = 1'b0;
        dec_instr_s.rs1           = rs1_s;
        dec_instr_s.rs2           = rs2_s;
        dec_instr_s.imm           = imm_b_s;
        case (funct3_s)
          3'b000: begin dec_instr_s.alu_op = ALU_SUB;  dec_instr_s.flags.expect_zero = 1'b1; end
          3'b001: begin dec_instr_s.alu_op = ALU_SUB;  dec_instr_s.flags.expect_zero = 1'b0; end
          3'b100: begin dec_instr_s.alu_op = ALU_SLT;  dec_instr_s.flags.expect_zero = 1'b0; end
          3'b101: begin dec_instr_s.alu_op = ALU_SLT;  dec_instr_s.flags.expect_zero = 1'b1; end
          3'b110: begin dec_instr_s.alu_op = ALU_SLTU; dec_instr_s.flags.expect_zero = 1'b0; end
          3'b111: begin dec_instr_s.alu_op = ALU_SLTU; dec_instr_s.flags.expect_zero = 1'b1; end
          default: dec_bad_s = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec_instr_s.flags.mem_read = 1'b1;
        dec_instr_s.rd             = rd_s;
        dec_instr_s.rs1            = rs1_s;
        dec_instr_s.imm            = imm_i_s;
        case (funct3_s)
          3'b000: begin dec_size_s = SZ_BYTE; dec_subword_s = 1'b1; end
          3'b001: begin dec_size_s = SZ_HALF; dec_subword_s = 1'b1; end
          3'b010: begin dec_size_s = SZ_WORD; end
          3'b100: begin dec_size_s = SZ_BYTE; dec_unsigned_s = 1'b1; dec_subword_s = 1'b1; end
          3'b101: begin dec_size_s = SZ_HALF; dec_unsigned_s = 1'b1; dec_subword_s = 1'b1; end
          default: dec_bad_s = 1'b1;
        endcase
      end
      OP_STORE: begin
        dec_instr_s.flags.mem_write = 1'b1;
        dec_instr_s.rs1             = rs1_s;
        dec_instr_s.rs2             = rs2_s;
        dec_instr_s.imm             = imm_s_s;
        case (funct3_s)
          3'b000: begin dec_size_s = SZ_BYTE; dec_subword_s = 1'b1; end
          3'b001: begin dec_size_s = SZ_HALF; dec_subword_s = 1'b1; end
          3'b010: begin dec_size_s = SZ_WORD; end
          default: dec_bad_s = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec_instr_s.rd  = rd_s;
        dec_instr_s.rs1 = rs1_s;
        case (funct3_s)
          3'b001: begin
            dec_instr_s.alu_op = ALU_SLL;
            dec_instr_s.imm    = imm_sh_s;
            dec_bad_s          = (funct7_s != 7'b0000000);
          end
          3'b101: begin
            dec_instr_s.alu_op = {funct7_s[5], funct3_s};
            dec_instr_s.imm    = imm_sh_s;
            dec_bad_s          = (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000);
          end
          default: begin
            // funct7 bits belong to the immediate here, so they never select SUB.
            dec_instr_s.alu_op = {1'b0, funct3_s};
            dec_instr_s.imm    = imm_i_s;
          end
        endcase
      end
      OP_REG: begin
        dec_instr_s.flags.use_imm = 1'b0;
        dec_instr_s.rd            = rd_s;
        dec_instr_s.rs1           = rs1_s;
        dec_instr_s.rs2           = rs2_s;
        dec_instr_s.imm           = '0;
        dec_instr_s.alu_op        = {funct7_s[5], funct3_s};
        if (funct7_s == 7'b0000000) begin
          dec_bad_s = 1'b0;
        end else if ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
          dec_bad_s = 1'b0;
        end else begin
          dec_bad_s = 1'b1;
        end
      end
      OP_FENCE: begin
        dec_bad_s = 1'b0;
      end
      OP_SYSTEM: begin
        if (in_word == 32'h0000_0073) begin
          dec_instr_s.flags.is_ecall = ENABLE_ECALL;
          dec_bad_s                  = !ENABLE_ECALL;
        end else if (in_word == 32'h0010_0073) begin
          dec_instr_s.flags.is_ebreak = 1'b1;
        end else begin
          dec_bad_s = 1'b1;
        end
      end
      default: dec_bad_s = 1'b1;
    endcase
  end

  assign dec_illegal_s = dec_bad_s | (dec_subword_s & !ENABLE_SUBWORD);

  // Illegal words are pushed as a flagged NOP so execute can trap precisely.
  always_comb begin
    entry_s.pc      = in_pc;
    entry_s.illegal = dec_illegal_s;
    if (dec_illegal_s) begin
      entry_s.instr        = nop_instr();
      entry_s.mem_size     = SZ_BYTE;
      entry_s.mem_unsigned = 1'b0;
    end else begin
      entry_s.instr        = dec_instr_s;
      entry_s.mem_size     = dec_size_s;
      entry_s.mem_unsigned = dec_unsigned_s;
    end
  end

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic             push_s;
  logic             pop_s;

  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < CW'(DEPTH)) || out_ready;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // FIFO and status next state; flush wins over push and pop.
  always_comb begin
    mem_d     = mem_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    error_d   = error_q;
    ill_cnt_d = ill_cnt_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_s) begin
        mem_d[wptr_q] = entry_s;
        wptr_d        = ptr_inc(wptr_q);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = ptr_inc(rptr_q);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push_s && dec_illegal_s) begin
        error_d   = 1'b1;
        ill_cnt_d = (ill_cnt_q == {CNT_W{1'b1}}) ? ill_cnt_q : ill_cnt_q + CNT_W'(1);
      end else begin
        error_d   = error_q;
        ill_cnt_d = ill_cnt_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      error_q   <= error_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  entry_t head_s;

  // Head presentation; an empty FIFO shows a NOP record and zeros.
  always_comb begin
    head_s = mem_q[rptr_q];
    if (out_valid) begin
      out_instr        = head_s.instr;
      out_pc           = head_s.pc;
      out_mem_size     = head_s.mem_size;
      out_mem_unsigned = head_s.mem_unsigned;
      out_illegal      = head_s.illegal;
    end else begin
      out_instr        = nop_instr();
      out_pc           = '0;
      out_mem_size     = 2'b00;
      out_mem_unsigned = 1'b0;
      out_illegal      = 1'b0;
    end
  end

  assign error         = error_q;
  assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: scoreboard queue of expected FIFO entries,
// plus a second instance with ECALL and sub-word accesses disabled.
module tb_decode_stage;
  import decode_pkg::*;

  localparam logic [8:0] F_BR  = 9'h100;
  localparam logic [8:0] F_LNK = 9'h080;
  localparam logic [8:0] F_EZ  = 9'h040;
  localparam logic [8:0] F_IMM = 9'h020;
  localparam logic [8:0] F_RD  = 9'h008;
  localparam logic [8:0] F_EC  = 9'h002;
  localparam logic [8:0] F_EB  = 9'h001;

  typedef struct packed {
    instruction_t instr;
    logic [31:0]  pc;
    logic [1:0]   size;
    logic         uns;
    logic         ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset, flush;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_word, in_pc, out_pc;
  instruction_t out_instr;
  logic [1:0] out_mem_size;
  logic out_mem_unsigned, out_illegal, error;
  logic [1:0] illegal_count;

  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_word, b_in_pc, b_out_pc;
  instruction_t b_out_instr;
  logic [1:0] b_out_mem_size;
  logic b_out_mem_unsigned, b_out_illegal, b_error;
  logic [7:0] b_illegal_count;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(2), .CNT_W(2), .ENABLE_SUBWORD(1'b1), .ENABLE_ECALL(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_mem_size(out_mem_size), .out_mem_unsigned(out_mem_unsigned), .out_illegal(out_illegal),
    .error(error), .illegal_count(illegal_count));

  decode_stage #(.XLEN(32), .DEPTH(2), .CNT_W(8), .ENABLE_SUBWORD(1'b0), .ENABLE_ECALL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_word(b_in_word), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr), .out_pc(b_out_pc),
    .out_mem_size(b_out_mem_size), .out_mem_unsigned(b_out_mem_unsigned), .out_illegal(b_out_illegal),
    .error(b_error), .illegal_count(b_illegal_count));

  logic [95:0] obs_a, obs_b;
  assign obs_a = {out_instr, out_pc, out_mem_size, out_mem_unsigned, out_illegal};
  assign obs_b = {b_out_instr, b_out_pc, b_out_mem_size, b_out_mem_unsigned, b_out_illegal};

  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;
  exp_t q[$];
  exp_t cur_exp;
  logic exp_err;
  logic [1:0] exp_cnt;
  logic last_acc;

  function automatic exp_t mk(input logic [8:0] f, input logic [3:0] alu, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                              input logic [31:0] pc, input logic [1:0] sz, input logic uns, input logic ill);
    exp_t e;
    e.instr = instruction_t'({f, alu, rd, rs1, rs2, imm});
    e.pc    = pc;
    e.size  = sz;
    e.uns   = uns;
    e.ill   = ill;
    return e;
  endfunction

  function automatic exp_t nop_e(input logic [31:0] pc);
    return mk(F_IMM, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, pc, 2'b00, 1'b0, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One cycle: compare against the model just after the negedge, update the model, wait.
  task automatic tick();
    exp_t e;
    logic ready_m;
    #1;
    ready_m = (q.size() < 2) || out_ready;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, ready_m);
    chk("error", error, exp_err);
    chk("illegal_count", illegal_count, exp_cnt);
    last_acc = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (out_ready && q.size() != 0) begin
        e = q.pop_front();
        n_pop++;
        chk("head_entry", obs_a, e);
      end
      if (in_valid && ready_m) begin
        q.push_back(cur_exp);
        last_acc = 1'b1;
        if (cur_exp.ill) begin
          exp_err = 1'b1;
          if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic put(input logic [31:0] w, input exp_t e);
    in_valid = 1'b1;
    in_word  = w;
    in_pc    = e.pc;
    cur_exp  = e;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    in_valid = 1'b0;
    chk("accept", last_acc, 1'b1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    tick();
  endtask

  task automatic bput(input logic [31:0] w, input exp_t e, input logic err, input logic [7:0] cnt);
    b_in_valid = 1'b1;
    b_in_word  = w;
    b_in_pc    = e.pc;
    #1;
    chk("b_in_ready", b_in_ready, 1'b1);
    tick();
    b_in_valid = 1'b0;
    chk("b_out_valid", b_out_valid, 1'b1);
    chk("b_entry", obs_b, e);
    chk("b_error", b_error, err);
    chk("b_illegal_count", b_illegal_count, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = 32'h0; in_pc = 32'h0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_word = 32'h0; b_in_pc = 32'h0; b_out_ready = 1'b1;
    exp_err = 1'b0; exp_cnt = 2'd0; last_acc = 1'b0; cur_exp = nop_e(32'h0);
    @(negedge clk); @(negedge clk);
    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_error", error, 1'b0);
    chk("rst_count", illegal_count, 2'd0);
    chk("rst_outputs", obs_a, mk(F_IMM, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0));
    reset = 1'b0;

    // ADDI with one-cycle latency
    out_ready = 1'b1;
    put(32'hFF60_0093, mk(F_IMM, 4'h0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFF6, 32'h100, 2'b00, 1'b0, 1'b0));
    chk("latency_valid", out_valid, 1'b1);
    drain();

    // Loads, branch, jump, shift, LUI
    put(32'h1000_A503, mk(F_IMM | F_RD, 4'h0, 5'd10, 5'd1, 5'd0, 32'h100, 32'h104, 2'b10, 1'b0, 1'b0));
    put(32'hFFF1_0283, mk(F_IMM | F_RD, 4'h0, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'h108, 2'b00, 1'b0, 1'b0));
    put(32'h0020_8463, mk(F_BR | F_EZ, 4'b1000, 5'd0, 5'd1, 5'd2, 32'h8, 32'h10C, 2'b00, 1'b0, 1'b0));
    put(32'h0100_00EF, mk(F_BR | F_LNK | F_EZ, 4'h0, 5'd1, 5'd0, 5'd0, 32'h10, 32'h110, 2'b00, 1'b0, 1'b0));
    put(32'h4033_D393, mk(F_IMM, 4'b1101, 5'd7, 5'd7, 5'd0, 32'h3, 32'h114, 2'b00, 1'b0, 1'b0));
    put(32'h1234_5337, mk(F_IMM, 4'b0100, 5'd6, 5'd0, 5'd0, 32'h1234_5000, 32'h118, 2'b00, 1'b0, 1'b0));
    drain();

    // Backpressure: third word held until execute consumes
    out_ready = 1'b0;
    p0 = n_pop;
    put(32'h0020_81B3, mk(9'h000, 4'h0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h200, 2'b00, 1'b0, 1'b0));
    put(32'h4011_8233, mk(9'h000, 4'b1000, 5'd4, 5'd3, 5'd1, 32'h0, 32'h204, 2'b00, 1'b0, 1'b0));
    chk("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_word = 32'h1234_5337; in_pc = 32'h208;
    cur_exp = mk(F_IMM, 4'b0100, 5'd6, 5'd0, 5'd0, 32'h1234_5000, 32'h208, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_acc) break;
    end
    in_valid = 1'b0;
    chk("held_accept", last_acc, 1'b1);
    drain();
    chk("backpressure_pops", n_pop - p0, 3);

    // Illegal words and counter saturation
    for (int i = 0; i < 3; i++) put(32'h0, nop_e(32'h300 + 32'(i * 4)));
    drain();
    chk("err_after3", error, 1'b1);
    chk("cnt_after3", illegal_count, 2'd3);
    put(32'h0, nop_e(32'h30C));
    put(32'h0, nop_e(32'h310));
    drain();
    chk("cnt_saturated", illegal_count, 2'd3);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    put(32'h0020_81B3, mk(9'h000, 4'h0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h400, 2'b00, 1'b0, 1'b0));
    put(32'h0, nop_e(32'h404));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_error", error, 1'b0);
    chk("async_rst_count", illegal_count, 2'd0);
    q.delete(); exp_err = 1'b0; exp_cnt = 2'd0;
    @(negedge clk);
    reset = 1'b0;

    // Flush drops buffered entries and the concurrent (illegal) push
    put(32'h0020_81B3, mk(9'h000, 4'h0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h500, 2'b00, 1'b0, 1'b0));
    put(32'h4033_D393, mk(F_IMM, 4'b1101, 5'd7, 5'd7, 5'd0, 32'h3, 32'h504, 2'b00, 1'b0, 1'b0));
    flush = 1'b1; in_valid = 1'b1; in_word = 32'h0; in_pc = 32'h508; cur_exp = nop_e(32'h508);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_error", error, 1'b0);
    tick();
    out_ready = 1'b1;
    put(32'h1000_A503, mk(F_IMM | F_RD, 4'h0, 5'd10, 5'd1, 5'd0, 32'h100, 32'h50C, 2'b10, 1'b0, 1'b0));
    drain();

    // ECALL / EBREAK, enabled
    put(32'h0000_0073, mk(F_IMM | F_EC, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h600, 2'b00, 1'b0, 1'b0));
    put(32'h0010_0073, mk(F_IMM | F_EB, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h604, 2'b00, 1'b0, 1'b0));
    put(32'h0005_4503, mk(F_IMM | F_RD, 4'h0, 5'd10, 5'd10, 5'd0, 32'h0, 32'h608, 2'b00, 1'b1, 1'b0));
    drain();

    // ECALL and sub-word disabled instance
    bput(32'h0000_0073, nop_e(32'h700), 1'b1, 8'd1);
    bput(32'h0010_0073, mk(F_IMM | F_EB, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h704, 2'b00, 1'b0, 1'b0), 1'b1, 8'd1);
    bput(32'hFFF1_0283, nop_e(32'h708), 1'b1, 8'd2);
    bput(32'h1000_A503, mk(F_IMM | F_RD, 4'h0, 5'd10, 5'd1, 5'd0, 32'h100, 32'h70C, 2'b10, 1'b0, 1'b0), 1'b1, 8'd2);
    bput(32'h0000_2063, nop_e(32'h710), 1'b1, 8'd3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, handshaked instruction-decode pipeline stage. It accepts 32-bit RV32I instruction words with their PC from fetch and decodes them into the project Instruction record. Decoded entries are buffered in a parametrised-depth FIFO towards execute. Compared with the plain combinational decoder it adds:
- valid/ready backpressure and flush
- sub-word loads/stores (LB/LH/LBU/LHU/SB/SH)
- optional ECALL and FENCE
- a sticky error flag and a saturating illegal-instruction counter

Parameters:
XLEN, 32, datapath/PC width; immediates are sign- or zero-extended to XLEN.
DEPTH, 2, output buffer entries (power of two, ≥1).
CNT_W, 8, width of the illegal-instruction counter.
ENABLE_SUBWORD, 1, when 0, B/H/BU/HU loads/stores are illegal.
ENABLE_ECALL, 1, when 0, ECALL is illegal.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  discard all buffered entries (branch redirect).
in_valid  in  1  fetch presents a word.
in_ready  out  1  stage can accept this cycle.
in_word  in  32  raw instruction.
in_pc  in  XLEN  PC of in_word.
out_valid  out  1  head entry valid.
out_ready  in  1  execute consumes head.
out_instr  out  Instruction  decoded record {flags, alu_op, rd, rs1, rs2, imm}.
out_pc  out  XLEN  PC of head entry.
out_mem_size  out  2  00 byte, 01 half, 10 word (meaningful only with RAM flags).
out_mem_unsigned  out  1  zero-extend load result.
out_illegal  out  1  head entry came from an illegal word.
error  out  1  sticky; set on any accepted illegal word, cleared only by reset.
illegal_count  out  CNT_W  accepted illegal words, saturating at all-ones.

Behaviour:
- Reset (async, any time): FIFO empty, out_valid=0, error=0, illegal_count=0, in_ready=1. Other outputs are don't-care while out_valid=0 but are driven to a NOP record and zeros.
- Accept occurs when in_valid && in_ready. Decode is combinational on in_word and the result is written into the FIFO tail. Latency is 1 cycle: a word accepted at edge N is visible at the head from edge N+1 when the FIFO was empty. There is no combinational path from in_word to any output.
- Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH) || out_ready. Pop and push in the same cycle is allowed when full: count is unchanged and no bubble is inserted.
- Simultaneous push and pop at count==0 is impossible because out_valid=0.
- flush: on the edge, count becomes 0 and any push in the same cycle is dropped. Flush has priority over push and pop. error and illegal_count are not updated for a word dropped by flush.
- Pointers wrap modulo DEPTH.
- Decode rules:
  - LUI: XOR with imm={imm20,12'b0}, rs1=0.
  - AUIPC: ADD, PC to src1.
  - JAL: branch + next-PC to rd + ALU-should-be-zero, ADD.
  - JALR (funct3=000): same as JAL plus an ALU_USE_IMM target through rs1.
  - B-type: SUB/SLT/SLTU, expected-zero from funct3 as in the existing decoder; funct3 01x is illegal.
  - Loads: funct3 000/001/010/100/101 give size/unsigned {byte,0}/{half,0}/{word,0}/{byte,1}/{half,1}. Other funct3 values are illegal, as are sub-word sizes when ENABLE_SUBWORD=0.
  - Stores: funct3 000/001/010; the rest are illegal.
  - OP-IMM and OP: ALU op {funct7[5],funct3}. Shift immediates are zero-extended 5-bit. Invalid funct7 is illegal.
  - FENCE (opcode 0001111): NOP, legal.
  - EBREAK: IS_EBREAK flag.
  - ECALL: IS_ECALL flag when enabled, else illegal.
  - Any other opcode is illegal.
- An illegal word is replaced by a NOP record (ADD, use-imm, rd=rs1=rs2=0, imm=0) with out_illegal=1 and is still pushed, so execute can trap precisely. On accept, error←1 and illegal_count←min(count+1, 2^CNT_W−1).
- out_pc, out_mem_size and out_mem_unsigned travel in the same FIFO entry as out_instr.

Test Plan:
1. Reset, then push ADDI x1,x0,-10 (0xFF600093), pc=0x100, out_ready=1 → next cycle out_valid=1, alu_op=ADD, rd=1, imm=0xFFFFFFF6, out_pc=0x100, out_illegal=0.
2. Push LW x10,0x100(x1) (0x1000A503) then LB x5,-1(x2) (0xFFF10283) → mem_size 10/unsigned 0 with imm=0x100, then mem_size 00/unsigned 0 with imm=0xFFFFFFFF, rd=5, rs1=2, in order.
3. out_ready=0 and push 3 words with DEPTH=2 → in_ready=0 after the 2nd accept. The 3rd word is held at fetch until out_ready=1, then in_ready=1 with no lost or duplicated entries.
4. Push 0x00000000 three times → three NOP entries with out_illegal=1, error=1, illegal_count=3. With CNT_W=2, push a 4th and a 5th → illegal_count stays at 3.
5. Two entries buffered, assert flush together with in_valid=1 → next cycle out_valid=0 and the pushed word is dropped. Assert reset mid-stream → out_valid=0, error=0 immediately (asynchronous).
6. ECALL (0x00000073) with ENABLE_ECALL=1 → IS_ECALL flag, out_illegal=0. With ENABLE_ECALL=0 → NOP with out_illegal=1. EBREAK (0x00100073) → IS_EBREAK flag.
